// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive controller:
//   - rx_state_e    : controller state (IDLE, RUN, DRAIN)
//   - NBITS_*       : legal receiver bit counts and the fallback value
//   - TICKS_PER_BIT : Tick strobes per bit period (baud x16)
//   - nbits_legal() : true when a requested bit count is supported
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rx_state_e;

  localparam logic [3:0] NBITS_6       = 4'd6;
  localparam logic [3:0] NBITS_7       = 4'd7;
  localparam logic [3:0] NBITS_8       = 4'd8;
  localparam logic [3:0] NBITS_DEFAULT = 4'd8;
  localparam logic [7:0] TICKS_PER_BIT = 8'd16;

  function automatic logic nbits_legal(input logic [3:0] n);
    case (n)
      NBITS_6, NBITS_7, NBITS_8: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// -----------------------------------------------------------------------------
// uart_byte_fifo
// Small byte FIFO between the capture logic and the consumer.
// A push and a pop in the same cycle are both honoured, even when full.
// A pop while empty is ignored; a push while full without a pop is dropped
// (the caller detects that case and flags it).
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset (flushes contents)
//   i_push, i_data   write request and byte
//   i_pop            read request (advance head)
//   o_data           head byte
//   o_level          occupancy, 0..DEPTH
//   o_full, o_empty  status flags
// -----------------------------------------------------------------------------
module uart_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [7:0]             i_data,
  output logic [7:0]             o_data,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ZERO = (AW+1)'(0);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == LVL_ZERO);
  assign o_full    = (r_count == LVL_FULL);
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_level   = r_count;

  // Storage, pointers (wrap naturally since DEPTH is a power of two) and count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= LVL_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Sequences the UART receiver: enables it on request, freezes the bit-count
// configuration while active, drains an in-flight frame on disable, captures
// completed bytes into a FIFO and flags overruns.
// Optional feature macro: UART_RX_CTRL_TIMEOUT_EN (idle-line timeout pulse).
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   Tick              baud x16 strobe
//   CfgEn, CfgNBits   receive request and requested data bits (6/7/8)
//   ClrErr            clears Overrun
//   RxDone, RxData    receiver done level and byte
//   RxEn, NBits       receiver enable and bit count
//   OutData/OutValid/OutReady  FIFO head handshake
//   Overrun           sticky byte-dropped flag
//   IdleTimeout       one-cycle idle pulse (0 unless the macro is defined)
//   Level             FIFO occupancy
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int DEPTH       = 4,
  parameter int CAPTURE_DLY = 2
`ifdef UART_RX_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_TICKS = 320
`endif
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Tick,
  input  logic                   CfgEn,
  input  logic [3:0]             CfgNBits,
  input  logic                   ClrErr,
  input  logic                   RxDone,
  input  logic [7:0]             RxData,
  output logic                   RxEn,
  output logic [3:0]             NBits,
  output logic [7:0]             OutData,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic                   Overrun,
  output logic                   IdleTimeout,
  output logic [$clog2(DEPTH):0] Level
);

  import uart_pkg::*;

  localparam int DW = $clog2(CAPTURE_DLY + 1);

  rx_state_e     r_state;
  rx_state_e     w_next_state;
  logic          r_rx_en;
  logic [3:0]    r_nbits;
  logic [7:0]    r_frame_cnt;
  logic [7:0]    w_frame_limit;
  logic          w_frame_hit;
  logic          r_rxdone_d;
  logic          r_pend;
  logic [DW-1:0] r_dly;
  logic          w_edge;
  logic          w_push;
  logic          w_lost;
  logic          w_drop;
  logic          r_overrun;
  logic          w_full;
  logic          w_empty;

  // One full frame (start + data + stop) expressed in Tick strobes.
  assign w_frame_limit = TICKS_PER_BIT * ({4'd0, r_nbits} + 8'd2);
  assign w_frame_hit   = Tick & ((r_frame_cnt + 8'd1) >= w_frame_limit);

  // Edges while idle are ignored; the receiver is not supposed to be running.
  assign w_edge = RxDone & ~r_rxdone_d & (r_state != IDLE);
  assign w_push = r_pend & (r_dly == DW'(1));
  // A new edge before the pending byte was sampled discards that byte.
  assign w_lost = w_edge & r_pend & ~w_push;
  assign w_drop = w_push & w_full & ~(OutReady & ~w_empty);

  // Next-state logic of the controller.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (CfgEn) w_next_state = RUN;
        else       w_next_state = IDLE;
      end
      RUN: begin
        if (!CfgEn) w_next_state = DRAIN;
        else        w_next_state = RUN;
      end
      DRAIN: begin
        if (CfgEn)                      w_next_state = RUN;
        else if (w_push || w_frame_hit) w_next_state = IDLE;
        else                            w_next_state = DRAIN;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register, receiver enable, bit-count config and drain frame counter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_rx_en     <= 1'b0;
      r_nbits     <= NBITS_DEFAULT;
      r_frame_cnt <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_rx_en <= (w_next_state != IDLE);
      if (r_state == IDLE) begin
        r_nbits <= nbits_legal(CfgNBits) ? CfgNBits : NBITS_DEFAULT;
      end
      if (r_state == RUN && w_next_state == DRAIN) begin
        r_frame_cnt <= 8'd0;
      end else if (r_state == DRAIN && Tick) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  // RxDone edge detect and capture delay; a new edge restarts the delay.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rxdone_d <= 1'b0;
      r_pend     <= 1'b0;
      r_dly      <= {DW{1'b0}};
    end else begin
      r_rxdone_d <= RxDone;
      if (w_edge) begin
        r_pend <= 1'b1;
        r_dly  <= DW'(CAPTURE_DLY);
      end else if (w_push) begin
        r_pend <= 1'b0;
        r_dly  <= {DW{1'b0}};
      end else if (r_pend) begin
        r_dly <= r_dly - DW'(1);
      end
    end
  end

  // Sticky overrun; a new overrun event wins over a simultaneous clear.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop || w_lost) begin
      r_overrun <= 1'b1;
    end else if (ClrErr) begin
      r_overrun <= 1'b0;
    end
  end

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_push  (w_push),
    .i_pop   (OutReady),
    .i_data  (RxData),
    .o_data  (OutData),
    .o_level (Level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign RxEn     = r_rx_en;
  assign NBits    = r_nbits;
  assign OutValid = ~w_empty;
  assign Overrun  = r_overrun;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_to_armed;
  logic          r_idle_to;

  // Idle-line timer: armed by a captured byte in RUN, fires once, then waits
  // for the next byte. Leaving RUN disarms it.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_to_cnt   <= {TW{1'b0}};
      r_to_armed <= 1'b0;
      r_idle_to  <= 1'b0;
    end else begin
      r_idle_to <= 1'b0;
      if (r_state == RUN) begin
        if (w_push) begin
          r_to_cnt   <= {TW{1'b0}};
          r_to_armed <= 1'b1;
        end else if (r_to_armed && Tick) begin
          if (r_to_cnt == TW'(TIMEOUT_TICKS - 1)) begin
            r_idle_to  <= 1'b1;
            r_to_armed <= 1'b0;
            r_to_cnt   <= {TW{1'b0}};
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
      end else begin
        r_to_armed <= 1'b0;
        r_to_cnt   <= {TW{1'b0}};
      end
    end
  end

  assign IdleTimeout = r_idle_to;
`else
  assign IdleTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed scenarios followed by randomized traffic. A behavioural model
// (flags, a byte queue and a capture deadline) predicts every output; one
// process compares DUT against it each cycle, and directed steps add literal
// expectations for the key scenarios.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;
  localparam int DLY   = 2;
`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TIMEOUT_TICKS = 320;
`endif

  logic       Clk = 1'b0;
  logic       Rst, Tick, CfgEn, ClrErr, RxDone, OutReady;
  logic [3:0] CfgNBits;
  logic [7:0] RxData;
  logic       RxEn, OutValid, Overrun, IdleTimeout;
  logic [3:0] NBits;
  logic [7:0] OutData;
  logic [2:0] Level;

  uart_rx_ctrl #(.DEPTH(DEPTH), .CAPTURE_DLY(DLY)) dut (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .CfgEn(CfgEn), .CfgNBits(CfgNBits),
    .ClrErr(ClrErr), .RxDone(RxDone), .RxData(RxData), .RxEn(RxEn),
    .NBits(NBits), .OutData(OutData), .OutValid(OutValid),
    .OutReady(OutReady), .Overrun(Overrun), .IdleTimeout(IdleTimeout),
    .Level(Level)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // model state
  logic [7:0] q[$];
  bit         m_on, m_drain, m_ovr, m_pend, m_prev, m_to_arm, m_to_pulse;
  int         m_dcnt, m_nbits, m_to_cnt;
  longint     cyc = 0;
  longint     m_tpush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic model_step();
    bit edge_s, push_now, pop, drop, lost, in_run;
    logic [7:0] d;
    cyc++;
    if (Rst) begin
      m_on = 0; m_drain = 0; m_dcnt = 0; m_nbits = 8; q.delete();
      m_ovr = 0; m_pend = 0; m_prev = 0;
      m_to_arm = 0; m_to_cnt = 0; m_to_pulse = 0;
      return;
    end
    edge_s   = RxDone && !m_prev;
    m_prev   = RxDone;
    push_now = m_pend && (cyc == m_tpush);
    pop      = OutReady && (q.size() > 0);
    drop     = push_now && (q.size() == DEPTH) && !pop;
    lost     = edge_s && m_on && m_pend && !push_now;
    in_run   = m_on && !m_drain;
    if (lost || drop) m_ovr = 1;
    else if (ClrErr)  m_ovr = 0;
    if (pop) d = q.pop_front();
    if (push_now && !drop) q.push_back(RxData);
`ifdef UART_RX_CTRL_TIMEOUT_EN
    m_to_pulse = 0;
    if (in_run) begin
      if (push_now) begin
        m_to_cnt = 0; m_to_arm = 1;
      end else if (m_to_arm && Tick) begin
        m_to_cnt++;
        if (m_to_cnt == TIMEOUT_TICKS) begin
          m_to_pulse = 1; m_to_arm = 0;
        end
      end
    end else begin
      m_to_arm = 0; m_to_cnt = 0;
    end
`endif
    if (push_now) m_pend = 0;
    if (edge_s && m_on) begin
      m_pend  = 1;
      m_tpush = cyc + DLY;
    end
    if (!m_on) begin
      m_nbits = (CfgNBits inside {4'd6, 4'd7, 4'd8}) ? int'(CfgNBits) : 8;
      if (CfgEn) begin m_on = 1; m_drain = 0; end
    end else if (!m_drain) begin
      if (!CfgEn) begin m_drain = 1; m_dcnt = 0; end
    end else begin
      if (CfgEn) m_drain = 0;
      else if (push_now) m_on = 0;
      else if (Tick && (m_dcnt + 1 >= 16 * (m_nbits + 2))) m_on = 0;
      if (Tick) m_dcnt++;
    end
  endtask

  // model advances on every active edge
  initial forever begin
    @(posedge Clk);
    model_step();
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge Clk);
    if (chk_en) begin
      check("rx_en", RxEn, m_on);
      check("nbits", NBits, m_nbits);
      check("out_valid", OutValid, q.size() > 0);
      check("level", Level, q.size());
      check("overrun", Overrun, m_ovr);
      check("idle_timeout", IdleTimeout, m_to_pulse);
      if (q.size() > 0) check("out_data", OutData, q[0]);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit rdy_at_push);
    RxData = b; RxDone = 1'b1;
    adv(2);
    RxDone = 1'b0; OutReady = rdy_at_push;
    adv(1);
    OutReady = 1'b0;
  endtask

  task automatic pop_expect(input logic [7:0] b);
    check("fifo_order", OutData, b);
    OutReady = 1'b1;
    adv(1);
    OutReady = 1'b0;
  endtask

  task automatic drain_ticks(output int n);
    CfgEn = 1'b0; Tick = 1'b0;
    adv(1);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      Tick = 1'b1; adv(1); Tick = 1'b0;
      n++;
      adv(1);
      if (!RxEn) break;
    end
  endtask

  initial begin
    int n, pulses, at;
    Rst = 1'b1; Tick = 1'b0; CfgEn = 1'b0; CfgNBits = 4'd8; ClrErr = 1'b0;
    RxDone = 1'b0; RxData = 8'h00; OutReady = 1'b0;
    adv(2);
    chk_en = 1'b1;
    check("rst_rx_en", RxEn, 1'b0);
    check("rst_nbits", NBits, 4'd8);
    check("rst_valid", OutValid, 1'b0);
    check("rst_data", OutData, 8'h00);
    check("rst_level", Level, 3'd0);
    check("rst_overrun", Overrun, 1'b0);
    check("rst_timeout", IdleTimeout, 1'b0);
    Rst = 1'b0;

    // enable with 7 bits; later config change must not apply
    CfgNBits = 4'd7; CfgEn = 1'b1;
    adv(1);
    check("cfg_rx_en", RxEn, 1'b1);
    check("cfg_nbits7", NBits, 4'd7);
    CfgNBits = 4'd6;
    adv(3);
    check("cfg_frozen", NBits, 4'd7);

    // single byte
    send_byte(8'hA5, 1'b0);
    check("one_valid", OutValid, 1'b1);
    check("one_data", OutData, 8'hA5);
    check("one_level", Level, 3'd1);
    OutReady = 1'b1; adv(1); OutReady = 1'b0;
    check("one_popped", Level, 3'd0);

    // five bytes into a four-entry FIFO
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 * (i + 1)), 1'b0);
    check("ovr_level", Level, 3'd4);
    check("ovr_flag", Overrun, 1'b1);
    ClrErr = 1'b1; adv(1); ClrErr = 1'b0;
    check("ovr_clear", Overrun, 1'b0);

    // push and pop together while full
    send_byte(8'h66, 1'b1);
    check("full_pp_level", Level, 3'd4);
    check("full_pp_ovr", Overrun, 1'b0);
    pop_expect(8'h22); pop_expect(8'h33); pop_expect(8'h44); pop_expect(8'h66);
    check("drained_level", Level, 3'd0);

    // drain with no traffic: 7 bits -> 144 ticks, then 8 bits -> 160 ticks
    drain_ticks(n);
    check("drain_ticks_7", n, 144);
    CfgNBits = 4'd8; CfgEn = 1'b1;
    adv(1);
    check("nbits8", NBits, 4'd8);
    drain_ticks(n);
    check("drain_ticks_8", n, 160);

    // drain interrupted by a byte arriving at tick 50
    CfgEn = 1'b1; adv(2);
    CfgEn = 1'b0; Tick = 1'b0; adv(1);
    for (int k = 0; k < 50; k++) begin
      Tick = 1'b1; adv(1); Tick = 1'b0; adv(1);
    end
    check("drain_still_on", RxEn, 1'b1);
    send_byte(8'h5A, 1'b0);
    check("drain_byte_off", RxEn, 1'b0);
    check("drain_byte_data", OutData, 8'h5A);
    pop_expect(8'h5A);

    // illegal bit count in IDLE
    CfgNBits = 4'd9; adv(2);
    check("illegal_nbits", NBits, 4'd8);
    CfgNBits = 4'd6; adv(1);
    check("nbits6", NBits, 4'd6);

`ifdef UART_RX_CTRL_TIMEOUT_EN
    CfgNBits = 4'd8; CfgEn = 1'b1; adv(1);
    send_byte(8'h3C, 1'b0);
    pulses = 0; at = 0;
    for (int k = 1; k <= 700; k++) begin
      Tick = 1'b1; adv(1);
      if (IdleTimeout) begin
        pulses++;
        if (at == 0) at = k;
      end
    end
    Tick = 1'b0;
    check("timeout_pulses", pulses, 1);
    check("timeout_tick", at, TIMEOUT_TICKS);
    OutReady = 1'b1; adv(1); OutReady = 1'b0;
`endif

    // randomized traffic against the model
    CfgEn = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      Rst      = ($urandom_range(0, 599) == 0);
      Tick     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) CfgEn = ~CfgEn;
      if ($urandom_range(0, 19) == 0) CfgNBits = 4'($urandom_range(0, 15));
      RxDone   = ($urandom_range(0, 7) == 0);
      RxData   = 8'($urandom);
      OutReady = ($urandom_range(0, 2) == 0);
      ClrErr   = ($urandom_range(0, 29) == 0);
      adv(1);
    end
    Rst = 1'b0; RxDone = 1'b0; Tick = 1'b0; OutReady = 1'b0; ClrErr = 1'b0;
    adv(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
